// File: rtl/avalon_arbiter_2to1_if.sv
// Avalon-MM bus bundle: 32-bit address/data, 4-bit byteenable,
// parameterised burstcount. The "host" side drives commands, the "agent" side answers.
interface avalon_if #(
    parameter int BURSTCOUNT_W = 4
);
    logic [31:0]             address;
    logic                    read;
    logic                    write;
    logic [31:0]             writedata;
    logic [3:0]              byteenable;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic                    waitrequest;
    logic [31:0]             readdata;
    logic                    readdatavalid;

    modport host (
        output address, read, write, writedata, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport agent (
        input  address, read, write, writedata, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_arbiter_2to1.sv
// Two-host Avalon-MM arbiter with burst-atomic grants onto one shared agent.
// Compile-time option ARB_FIXED_PRIO_EN: host0 always wins on contention;
// left undefined, contention is resolved round-robin.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no owner, both hosts stalled, choose a winner
// ST_WR      | owner is transferring a write burst
// ST_RD_CMD  | owner's read command forwarded, waiting for acceptance
// ST_RD_DATA | read command issued once, counting returned beats
module avalon_arbiter_2to1 #(
    parameter int BURSTCOUNT_W = 4
) (
    input  logic    clk,
    input  logic    reset,
    avalon_if.agent host0,
    avalon_if.agent host1,
    avalon_if.host  mem
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR      = 2'd1;
    localparam logic [1:0] ST_RD_CMD  = 2'd2;
    localparam logic [1:0] ST_RD_DATA = 2'd3;

    localparam logic [BURSTCOUNT_W-1:0] BC_ONE = {{(BURSTCOUNT_W-1){1'b0}}, 1'b1};

    logic [1:0]              state;
    logic                    gnt;
    logic [BURSTCOUNT_W-1:0] beat_cnt;
    logic [BURSTCOUNT_W-1:0] burst_len;

    logic                    req0, req1, any_req;
    logic                    win, win_write;
    logic [BURSTCOUNT_W-1:0] win_bc;
    logic                    granted, granted0, granted1;
    logic                    fwd_read, fwd_write, last_beat;

    logic [31:0]             g_address, g_writedata;
    logic [3:0]              g_byteenable;
    logic [BURSTCOUNT_W-1:0] g_burstcount;
    logic                    g_read, g_write;

    assign req0    = host0.read | host0.write;
    assign req1    = host1.read | host1.write;
    assign any_req = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
    assign win = ~req0;
`else
    logic last;

    // Remember the most recent winner; host1 preset so host0 goes first
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if ((state == ST_IDLE) && any_req) begin
            last <= win;
        end
    end

    assign win = (req0 & req1) ? ~last : req1;
`endif

    assign win_write = win ? host1.write      : host0.write;
    assign win_bc    = win ? host1.burstcount : host0.burstcount;

    assign g_address    = gnt ? host1.address    : host0.address;
    assign g_writedata  = gnt ? host1.writedata  : host0.writedata;
    assign g_byteenable = gnt ? host1.byteenable : host0.byteenable;
    assign g_burstcount = gnt ? host1.burstcount : host0.burstcount;
    assign g_read       = gnt ? host1.read       : host0.read;
    assign g_write      = gnt ? host1.write      : host0.write;

    assign granted  = (state != ST_IDLE);
    assign granted0 = granted & ~gnt;
    assign granted1 = granted &  gnt;

    // A read+write host is granted as a write, so read is only ever forwarded in ST_RD_CMD
    assign fwd_write = (state == ST_WR)     & g_write;
    assign fwd_read  = (state == ST_RD_CMD) & g_read;
    assign last_beat = (beat_cnt == (burst_len - BC_ONE));

    // Forward the owner's command downstream; everything reads as zero while idle
    always_comb begin
        mem.address    = '0;
        mem.writedata  = '0;
        mem.byteenable = '0;
        mem.burstcount = '0;
        if (granted) begin
            mem.address    = g_address;
            mem.writedata  = g_writedata;
            mem.byteenable = g_byteenable;
            mem.burstcount = g_burstcount;
        end
        mem.read  = fwd_read;
        mem.write = fwd_write;
    end

    assign host0.waitrequest   = granted0 ? mem.waitrequest : 1'b1;
    assign host1.waitrequest   = granted1 ? mem.waitrequest : 1'b1;
    assign host0.readdatavalid = granted0 & mem.readdatavalid;
    assign host1.readdatavalid = granted1 & mem.readdatavalid;
    assign host0.readdata      = mem.readdata;
    assign host1.readdata      = mem.readdata;

    // Grant sequencing and beat counting; one idle cycle always separates grants
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            beat_cnt  <= '0;
            burst_len <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt       <= win;
                        burst_len <= (win_bc == '0) ? BC_ONE : win_bc;
                        beat_cnt  <= '0;
                        state     <= win_write ? ST_WR : ST_RD_CMD;
                    end
                end
                ST_WR: begin
                    if (fwd_write & ~mem.waitrequest) begin
                        if (last_beat) state <= ST_IDLE;
                        else           beat_cnt <= beat_cnt + BC_ONE;
                    end
                end
                ST_RD_CMD: begin
                    if (fwd_read & ~mem.waitrequest) state <= ST_RD_DATA;
                end
                default: begin
                    if (mem.readdatavalid) begin
                        if (last_beat) state <= ST_IDLE;
                        else           beat_cnt <= beat_cnt + BC_ONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_arbiter_2to1.sv
// Bench for avalon_arbiter_2to1: contention vector table, multi-cycle corner
// sequences, and randomized traffic checked against a shadow memory per host.
module tb_avalon_arbiter_2to1;
    localparam logic [31:0] IDLE_D = 32'h1234_5678;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    avalon_if #(.BURSTCOUNT_W(4)) h0_if ();
    avalon_if #(.BURSTCOUNT_W(4)) h1_if ();
    avalon_if #(.BURSTCOUNT_W(4)) mem_if ();

    avalon_arbiter_2to1 #(.BURSTCOUNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .host0 (h0_if),
        .host1 (h1_if),
        .mem   (mem_if)
    );

    // host-side drive variables
    logic [31:0] h_addr [2];
    logic [31:0] h_wd   [2];
    logic [3:0]  h_bc   [2];
    logic [3:0]  h_be   [2];
    logic        h_rd   [2];
    logic        h_wr   [2];
    logic        h_wait [2];
    logic        h_rdv  [2];
    logic [31:0] h_rdata[2];

    assign h0_if.address = h_addr[0]; assign h1_if.address = h_addr[1];
    assign h0_if.writedata = h_wd[0]; assign h1_if.writedata = h_wd[1];
    assign h0_if.burstcount = h_bc[0]; assign h1_if.burstcount = h_bc[1];
    assign h0_if.byteenable = h_be[0]; assign h1_if.byteenable = h_be[1];
    assign h0_if.read = h_rd[0]; assign h1_if.read = h_rd[1];
    assign h0_if.write = h_wr[0]; assign h1_if.write = h_wr[1];
    assign h_wait[0] = h0_if.waitrequest; assign h_wait[1] = h1_if.waitrequest;
    assign h_rdv[0] = h0_if.readdatavalid; assign h_rdv[1] = h1_if.readdatavalid;
    assign h_rdata[0] = h0_if.readdata; assign h_rdata[1] = h1_if.readdata;

    // memory agent model
    logic        m_wait, m_rdv;
    logic [31:0] m_rdata;
    assign mem_if.waitrequest   = m_wait;
    assign mem_if.readdatavalid = m_rdv;
    assign mem_if.readdata      = m_rdata;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] rq[$];
    int          ag_mode = 0;   // 0 no stalls, 1 random stalls/gaps, 2 stall before beats 2 and 3
    int          wr_beat = 0;
    int          wr_len  = 1;
    logic [31:0] wr_base = '0;
    bit          stalled = 0;
    int          rd_cmds = 0;
    int          rd_seen = 0;

    initial begin
        m_wait = 1'b1; m_rdv = 1'b0; m_rdata = IDLE_D;
        forever begin
            @(negedge clk);
            case (ag_mode)
                1: m_wait = ($urandom_range(0, 2) == 0);
                2: begin
                    if ((wr_beat == 1 || wr_beat == 2) && !stalled) begin
                        m_wait = 1'b1; stalled = 1;
                    end else m_wait = 1'b0;
                end
                default: m_wait = 1'b0;
            endcase
            if (rq.size() > 0 && (ag_mode != 1 || $urandom_range(0, 3) != 0)) begin
                m_rdv   = 1'b1;
                m_rdata = mem_arr.exists(rq[0]) ? mem_arr[rq[0]] : 32'hBAD0_BAD0;
            end else begin
                m_rdv   = 1'b0;
                m_rdata = IDLE_D;
            end
            #4;
            if (reset) begin
                wr_beat = 0; stalled = 0; rq.delete();
            end else begin
                if (mem_if.read) rd_seen++;
                if (m_rdv) void'(rq.pop_front());
                if (mem_if.write && !m_wait) begin
                    if (wr_beat == 0) begin
                        wr_base = mem_if.address;
                        wr_len  = (mem_if.burstcount == 4'd0) ? 1 : int'(mem_if.burstcount);
                    end
                    mem_arr[wr_base + 32'(4 * wr_beat)] = mem_if.writedata;
                    wr_beat++;
                    stalled = 0;
                    if (wr_beat == wr_len) wr_beat = 0;
                end
                if (mem_if.read && !m_wait) begin
                    rd_cmds++;
                    for (int k = 0; k < ((mem_if.burstcount == 4'd0) ? 1 : int'(mem_if.burstcount)); k++)
                        rq.push_back(mem_if.address + 32'(4 * k));
                end
            end
        end
    end

    // both hosts must never be served in the same cycle
    int mutex_err = 0;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if ((!h_wait[0] && !h_wait[1]) || (h_rdv[0] && h_rdv[1])) mutex_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
    endtask

    int          rcnt [2];
    logic [31:0] rbuf [2][16];

    // One Avalon transaction from host n; returns request, first-accept and completion cycles.
    task automatic host_txn(input int n, input bit wr, input bit rdwr, input logic [31:0] addr,
                            input logic [3:0] bc, input logic [31:0] dbase,
                            output int t_req, output int t_acc, output int t_done);
        int nb, beat, budget;
        nb = (bc == 4'd0) ? 1 : int'(bc);
        t_req = -1; t_acc = -1; t_done = -1; beat = 0; budget = 0;
        rcnt[n] = 0;
        @(negedge clk);
        h_addr[n] = addr; h_bc[n] = bc; h_be[n] = 4'hF; h_wd[n] = dbase;
        h_wr[n] = wr; h_rd[n] = !wr || rdwr;
        forever begin
            #4;
            if (t_req < 0) t_req = cyc;
            if (!h_wait[n]) begin
                if (t_acc < 0) t_acc = cyc;
                beat++;
                if (!wr || beat == nb) begin
                    t_done = cyc;
                    break;
                end
            end
            budget++;
            if (budget > 300) begin
                timeout_fail($sformatf("host%0d command", n));
                break;
            end
            @(negedge clk);
            h_wd[n] = dbase + 32'(beat);
        end
        @(negedge clk);
        h_wr[n] = 1'b0; h_rd[n] = 1'b0;
        if (!wr && t_acc >= 0) begin
            budget = 0;
            while (rcnt[n] < nb) begin
                #4;
                if (h_rdv[n]) begin
                    rbuf[n][rcnt[n]] = h_rdata[n];
                    rcnt[n]++;
                    t_done = cyc;
                end
                budget++;
                if (budget > 300) begin
                    timeout_fail($sformatf("host%0d read data", n));
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    // randomized traffic: reference is a per-address shadow memory per host region
    logic [31:0] shadow [logic [31:0]];
    int          slen [2][8];

    task automatic rand_op(input int n);
        int slot, len, nb, q, a, d;
        logic [31:0] base, db;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        slot = $urandom_range(0, 7);
        base = 32'h0000_2000 + 32'(n * 32'h1000) + 32'(slot * 32);
        if (slen[n][slot] == 0 || $urandom_range(0, 1) == 0) begin
            len = $urandom_range(0, 8);
            nb  = (len == 0) ? 1 : len;
            db  = $urandom;
            host_txn(n, 1'b1, 1'b0, base, 4'(len), db, q, a, d);
            for (int k = 0; k < nb; k++) shadow[base + 32'(4 * k)] = db + 32'(k);
            if (nb > slen[n][slot]) slen[n][slot] = nb;
        end else begin
            len = $urandom_range(1, slen[n][slot]);
            host_txn(n, 1'b0, 1'b0, base, 4'(len), 32'h0, q, a, d);
            check($sformatf("rand host%0d beats", n), 32'(rcnt[n]), 32'(len));
            for (int k = 0; k < rcnt[n]; k++)
                check($sformatf("rand host%0d data %0h", n, base + 32'(4 * k)),
                      rbuf[n][k], shadow[base + 32'(4 * k)]);
        end
    endtask

    typedef struct {
        bit       en0;
        bit       wr0;
        logic [3:0] bc0;
        bit       en1;
        bit       wr1;
        logic [3:0] bc1;
        int       exp_rr;
        int       exp_fx;
    } vec_t;

    vec_t vt[8];
    int   q[2], a[2], d[2];
    int   f, s, k0, snap_rd, snap_seen, acc, budget;

    initial begin
        // contention table starting from reset (round-robin winner follows the last grant)
        vt[0] = '{1, 1, 4'd1, 1, 1, 4'd1, 0, 0};
        vt[1] = '{1, 1, 4'd1, 0, 0, 4'd0, 0, 0};
        vt[2] = '{1, 1, 4'd1, 1, 1, 4'd1, 1, 0};
        vt[3] = '{1, 0, 4'd1, 1, 0, 4'd2, 1, 0};
        vt[4] = '{0, 0, 4'd0, 1, 0, 4'd2, 1, 1};
        vt[5] = '{1, 1, 4'd2, 1, 0, 4'd3, 0, 0};
        vt[6] = '{1, 0, 4'd1, 0, 0, 4'd0, 0, 0};
        vt[7] = '{1, 0, 4'd2, 1, 1, 4'd3, 1, 0};

        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            h_addr[n] = '0; h_wd[n] = '0; h_bc[n] = '0; h_be[n] = '0;
            h_rd[n] = 1'b0; h_wr[n] = 1'b0;
        end
        h_addr[0] = 32'h55; h_wr[0] = 1'b1; h_bc[0] = 4'd3; h_wd[0] = 32'h99; h_be[0] = 4'hF;
        repeat (3) @(negedge clk);
        #4;
        check("reset mem.read", 32'(mem_if.read), 32'd0);
        check("reset mem.write", 32'(mem_if.write), 32'd0);
        check("reset mem.address", mem_if.address, 32'd0);
        check("reset mem.writedata", mem_if.writedata, 32'd0);
        check("reset mem.byteenable", 32'(mem_if.byteenable), 32'd0);
        check("reset mem.burstcount", 32'(mem_if.burstcount), 32'd0);
        check("reset host0 waitrequest", 32'(h_wait[0]), 32'd1);
        check("reset host1 waitrequest", 32'(h_wait[1]), 32'd1);
        check("reset host0 readdatavalid", 32'(h_rdv[0]), 32'd0);
        check("reset host0 readdata", h_rdata[0], IDLE_D);
        check("reset host1 readdata", h_rdata[1], IDLE_D);
        @(negedge clk);
        h_wr[0] = 1'b0; h_addr[0] = '0; h_bc[0] = '0; h_wd[0] = '0;
        @(negedge clk);
        reset = 1'b0;

        // contention / solo vectors
        for (int i = 0; i < 8; i++) begin
            q = '{-1, -1}; a = '{-1, -1}; d = '{-1, -1};
            fork
                if (vt[i].en0) host_txn(0, vt[i].wr0, 1'b0, 32'h100, vt[i].bc0, 32'h0A00_0000 + 32'(i * 16), q[0], a[0], d[0]);
                if (vt[i].en1) host_txn(1, vt[i].wr1, 1'b0, 32'h500, vt[i].bc1, 32'h0B00_0000 + 32'(i * 16), q[1], a[1], d[1]);
            join
            if (vt[i].en0 && vt[i].en1) begin
`ifdef ARB_FIXED_PRIO_EN
                f = vt[i].exp_fx;
`else
                f = vt[i].exp_rr;
`endif
                s = 1 - f;
                check($sformatf("vec%0d first host%0d", i, f), 32'(a[f] < a[s]), 32'd1);
                check($sformatf("vec%0d first latency", i), 32'(a[f] - q[f]), 32'd1);
                check($sformatf("vec%0d bubble", i), 32'(a[s]), 32'(d[f] + 2));
            end else begin
                k0 = vt[i].en0 ? 0 : 1;
                check($sformatf("vec%0d solo latency", i), 32'(a[k0] - q[k0]), 32'd1);
            end
        end

        // single write then read back
        host_txn(0, 1'b1, 1'b0, 32'h10, 4'd1, 32'hDEAD_BEEF, q[0], a[0], d[0]);
        check("wr latency", 32'(a[0] - q[0]), 32'd1);
        check("wr stored", mem_arr.exists(32'h10) ? mem_arr[32'h10] : 32'hX, 32'hDEAD_BEEF);
        host_txn(0, 1'b0, 1'b0, 32'h10, 4'd1, 32'h0, q[0], a[0], d[0]);
        check("rd beats", 32'(rcnt[0]), 32'd1);
        check("rd data", rbuf[0][0], 32'hDEAD_BEEF);
        acc = 0;
        repeat (3) begin
            #4; if (h_rdv[0]) acc++;
            @(negedge clk);
        end
        check("rd no extra valid", 32'(acc), 32'd0);

        // 4-beat write with stalls before beats 2 and 3; host1 arrives mid-burst
        ag_mode = 2;
        fork
            host_txn(0, 1'b1, 1'b0, 32'h40, 4'd4, 32'hB000_0000, q[0], a[0], d[0]);
            begin
                repeat (2) @(negedge clk);
                host_txn(1, 1'b1, 1'b0, 32'h140, 4'd1, 32'h11, q[1], a[1], d[1]);
            end
        join
        ag_mode = 0;
        check("burst4 duration", 32'(d[0] - a[0]), 32'd5);
        for (int k = 0; k < 4; k++)
            check($sformatf("burst4 beat%0d", k),
                  mem_arr.exists(32'h40 + 32'(4 * k)) ? mem_arr[32'h40 + 32'(4 * k)] : 32'hX,
                  32'hB000_0000 + 32'(k));
        check("burst4 host1 after", 32'(a[1]), 32'(d[0] + 2));

        // host1 8-beat read while host0 waits
        host_txn(1, 1'b1, 1'b0, 32'h580, 4'd8, 32'h5000_0000, q[1], a[1], d[1]);
        snap_rd = rd_cmds; snap_seen = rd_seen;
        fork
            host_txn(1, 1'b0, 1'b0, 32'h580, 4'd8, 32'h0, q[1], a[1], d[1]);
            begin
                repeat (2) @(negedge clk);
                host_txn(0, 1'b1, 1'b0, 32'h180, 4'd1, 32'h77, q[0], a[0], d[0]);
            end
        join
        check("rd8 commands accepted", 32'(rd_cmds - snap_rd), 32'd1);
        check("rd8 read high cycles", 32'(rd_seen - snap_seen), 32'd1);
        check("rd8 beats", 32'(rcnt[1]), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("rd8 beat%0d", k), rbuf[1][k], 32'h5000_0000 + 32'(k));
        check("rd8 host0 after", 32'(a[0]), 32'(d[1] + 2));

        // reset in the middle of a 4-beat write
        @(negedge clk);
        h_addr[0] = 32'h200; h_bc[0] = 4'd4; h_be[0] = 4'hF; h_wd[0] = 32'hA0; h_wr[0] = 1'b1;
        acc = 0; budget = 0;
        forever begin
            #4;
            if (!h_wait[0]) acc++;
            if (acc == 2) break;
            budget++;
            if (budget > 20) begin timeout_fail("midreset beats"); break; end
            @(negedge clk);
            h_wd[0] = 32'hA0 + 32'(acc);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #4;
        check("midreset mem.write", 32'(mem_if.write), 32'd0);
        check("midreset host0 wait", 32'(h_wait[0]), 32'd1);
        check("midreset host1 wait", 32'(h_wait[1]), 32'd1);
        @(negedge clk);
        reset = 1'b0; h_wr[0] = 1'b0;
        host_txn(1, 1'b1, 1'b0, 32'h300, 4'd1, 32'h31, q[1], a[1], d[1]);
        check("postreset latency", 32'(a[1] - q[1]), 32'd1);
        check("postreset stored", mem_arr.exists(32'h300) ? mem_arr[32'h300] : 32'hX, 32'h31);
        host_txn(0, 1'b1, 1'b0, 32'h220, 4'd4, 32'hE0, q[0], a[0], d[0]);
        check("postreset burst4 duration", 32'(d[0] - a[0]), 32'd3);

        // read+write together with burstcount 0: one write beat, no read
        snap_seen = rd_seen;
        host_txn(0, 1'b1, 1'b1, 32'h60, 4'd0, 32'hC0FF_EE00, q[0], a[0], d[0]);
        check("rdwr single beat", 32'(d[0] - a[0]), 32'd0);
        check("rdwr no read", 32'(rd_seen - snap_seen), 32'd0);
        check("rdwr stored", mem_arr.exists(32'h60) ? mem_arr[32'h60] : 32'hX, 32'hC0FF_EE00);
        host_txn(1, 1'b1, 1'b0, 32'h64, 4'd1, 32'h64, q[1], a[1], d[1]);
        check("rdwr back to idle", 32'(a[1] - q[1]), 32'd1);

        // randomized traffic against the shadow model
        ag_mode = 1;
        for (int it = 0; it < 60; it++) begin
            fork
                rand_op(0);
                rand_op(1);
            join
        end
        ag_mode = 0;

        check("mutual exclusion", 32'(mutex_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: actual running required finished");
        $fatal(1, "global timeout");
    end
endmodule
